// File: rtl/calc_mon_pkg.sv
// Shared definitions for the calculator-family fairness monitor.
//   resp_e  : DUV response codes carried on each 2-bit response lane
//   CMD_NOP : command value meaning "no request"
//   clog2   : elaboration-time ceiling log2 used to size counters and pointers
package calc_mon_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_OVF  = 2'b10,
    RESP_INV  = 2'b11
  } resp_e;

  localparam int unsigned CMD_NOP = 0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/calc_mon_port_fifo.sv
// Per-port FIFO of request ages for calc_fair_monitor.
// Ports:
//   c_clk, reset    : clock, synchronous active-high reset
//   push_i          : append a new entry at age 0 (applied after any pop)
//   pop_i           : remove the head entry
//   age_en_i        : advance every stored age by one, saturating at TIMEOUT
//   head_age_o      : age of the oldest entry (meaningless when empty)
//   empty_o, full_o : registered occupancy flags
//   timeout_evt_o   : some surviving entry reaches TIMEOUT at the coming edge
module calc_mon_port_fifo
  import calc_mon_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned AGEW    = clog2(TIMEOUT + 1)
) (
  input  logic            c_clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            age_en_i,
  output logic [AGEW-1:0] head_age_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            timeout_evt_o
);

  localparam int unsigned PTRW = clog2(DEPTH);
  localparam int unsigned CNTW = clog2(DEPTH + 1);

  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AGEW-1:0] age_q [DEPTH];
  logic [AGEW-1:0] age_d [DEPTH];
  logic [PTRW-1:0] rel [DEPTH];
  logic [DEPTH-1:0] valid;

  assign head_age_o = age_q[head_q];
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CNTW'(DEPTH));

  always_comb begin
    timeout_evt_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Slot is live when its distance from head is below the occupancy.
      rel[i]   = PTRW'(i) - head_q;
      valid[i] = CNTW'(rel[i]) < cnt_q;
      age_d[i] = age_q[i];
      if (valid[i] && age_en_i && (age_q[i] != AGEW'(TIMEOUT))) begin
        age_d[i] = age_q[i] + AGEW'(1);
      end
      // An entry popped this cycle never reaches TIMEOUT.
      if (valid[i] && age_en_i && (age_q[i] == AGEW'(TIMEOUT - 1)) &&
          !(pop_i && (PTRW'(i) == head_q))) begin
        timeout_evt_o = 1'b1;
      end
    end
    // Written last so a push into the slot just popped (full FIFO) starts at 0.
    if (push_i) age_d[tail_q] = '0;
    head_d = head_q + PTRW'(pop_i);
    tail_d = tail_q + PTRW'(push_i);
    cnt_d  = cnt_q + CNTW'(push_i) - CNTW'(pop_i);
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: rtl/calc_fair_monitor.sv
// Protocol and fairness monitor for the N-port calculator family.
// Ports:
//   c_clk, reset, enable : clock, synchronous active-high reset, sample enable
//   req_cmd_in           : per-port command lanes, nonzero = new request
//   out_resp             : per-port 2-bit DUV response lanes, nonzero = response
//   err_spurious/overflow/timeout/starve : sticky per-port error flags
//   viol_count           : saturating count of cycles with any new error event
//   all_idle             : no port holds an outstanding request
module calc_fair_monitor
  import calc_mon_pkg::*;
#(
  parameter int unsigned NPORTS     = 4,
  parameter int unsigned CMDW       = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned MAX_BYPASS = 3,
  parameter int unsigned AGEW       = clog2(TIMEOUT + 1)
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NPORTS*CMDW-1:0] req_cmd_in,
  input  logic [NPORTS*2-1:0]    out_resp,
  output logic [NPORTS-1:0]      err_spurious,
  output logic [NPORTS-1:0]      err_overflow,
  output logic [NPORTS-1:0]      err_timeout,
  output logic [NPORTS-1:0]      err_starve,
  output logic [15:0]            viol_count,
  output logic                   all_idle
);

  localparam int unsigned BPW    = clog2(MAX_BYPASS + 2);
  localparam int unsigned BP_SAT = (32'd1 << BPW) - 1;

  logic [NPORTS-1:0] req_v, resp_v, push, pop, empty, full;
  logic [NPORTS-1:0] spur_evt, ovf_evt, tmo_evt, starve_evt;
  logic [AGEW-1:0]   head_age [NPORTS];
  logic [BPW-1:0]    bp_q [NPORTS];
  logic [BPW-1:0]    bp_d [NPORTS];
  logic [NPORTS-1:0] spur_q, spur_d, ovf_q, ovf_d, tmo_q, tmo_d, starve_q, starve_d;
  logic [15:0]       viol_q, viol_d;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    calc_mon_port_fifo #(
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT),
      .AGEW   (AGEW)
    ) u_fifo (
      .c_clk        (c_clk),
      .reset        (reset),
      .push_i       (push[p]),
      .pop_i        (pop[p]),
      .age_en_i     (enable),
      .head_age_o   (head_age[p]),
      .empty_o      (empty[p]),
      .full_o       (full[p]),
      .timeout_evt_o(tmo_evt[p])
    );
  end

  // Pop first, then push: a full FIFO popping this cycle can still accept.
  always_comb begin
    for (int unsigned p = 0; p < NPORTS; p++) begin
      req_v[p]    = req_cmd_in[p*CMDW +: CMDW] != CMDW'(CMD_NOP);
      resp_v[p]   = out_resp[p*2 +: 2] != RESP_NONE;
      pop[p]      = enable && resp_v[p] && !empty[p];
      push[p]     = enable && req_v[p] && (!full[p] || pop[p]);
      spur_evt[p] = enable && resp_v[p] && empty[p];
      ovf_evt[p]  = enable && req_v[p] && full[p] && !pop[p];
    end
  end

  // A bypass is a strictly younger head on another port completing while this
  // port's head waits; each such completion in a cycle counts separately.
  always_comb begin
    int unsigned inc;
    int unsigned sum;
    inc = 0;
    sum = 0;
    for (int unsigned q = 0; q < NPORTS; q++) begin
      bp_d[q]       = bp_q[q];
      starve_evt[q] = 1'b0;
      if (enable) begin
        if (pop[q] || empty[q]) begin
          bp_d[q] = '0;
        end else begin
          inc = 0;
          for (int unsigned p = 0; p < NPORTS; p++) begin
            if ((p != q) && pop[p] && (head_age[p] < head_age[q])) inc++;
          end
          sum           = 32'(bp_q[q]) + inc;
          bp_d[q]       = (sum > BP_SAT) ? BPW'(BP_SAT) : BPW'(sum);
          starve_evt[q] = (inc != 0) && (sum > MAX_BYPASS);
        end
      end
    end
  end

  always_comb begin
    spur_d   = spur_q | spur_evt;
    ovf_d    = ovf_q | ovf_evt;
    tmo_d    = tmo_q | tmo_evt;
    starve_d = starve_q | starve_evt;
    viol_d   = viol_q;
    if ((|{spur_evt, ovf_evt, tmo_evt, starve_evt}) && (viol_q != 16'hFFFF)) begin
      viol_d = viol_q + 16'd1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      spur_q   <= '0;
      ovf_q    <= '0;
      tmo_q    <= '0;
      starve_q <= '0;
      viol_q   <= '0;
      for (int unsigned q = 0; q < NPORTS; q++) bp_q[q] <= '0;
    end else begin
      spur_q   <= spur_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
      viol_q   <= viol_d;
      bp_q     <= bp_d;
    end
  end

  assign err_spurious = spur_q;
  assign err_overflow = ovf_q;
  assign err_timeout  = tmo_q;
  assign err_starve   = starve_q;
  assign viol_count   = viol_q;
  assign all_idle     = &empty;

endmodule

// File: doc/calc_fair_monitor.md
# calc_fair_monitor

Parametrised, synthesizable protocol and fairness monitor for the N-port calculator family. It sits beside the DUV in the testbench, sampling the shared per-port command inputs and the DUV response outputs. It tracks up to DEPTH outstanding requests per port with saturating ages and raises sticky per-port errors for spurious responses, queue overflow, timeout and starvation. It is the multi-outstanding successor of the 4-port single-outstanding fairness check.

## Interface
- NPORTS, 4, number of request/response ports
- CMDW, 4, command width per port
- DEPTH, 4, max outstanding requests per port (power of two, ≥2)
- TIMEOUT, 64, age in cycles at which an outstanding request is timed out (≥2)
- MAX_BYPASS, 3, number of younger requests on other ports that may complete before a port's oldest request
- AGEW, clog2(TIMEOUT+1), age counter width (derived)
- c_clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- enable  in  1  high: sample inputs; low: inputs ignored, all state frozen
- req_cmd_in  in  NPORTS*CMDW  port p (0-based, port p+1) at bits [p*CMDW +: CMDW]; nonzero = new request
- out_resp  in  NPORTS*2  DUV response per port at [p*2 +: 2]; 00 none, 01 ok, 10 overflow/underflow, 11 invalid
- err_spurious  out  NPORTS  sticky: response with no outstanding request
- err_overflow  out  NPORTS  sticky: request arrived with DEPTH outstanding and no same-cycle pop
- err_timeout  out  NPORTS  sticky: an outstanding request reached age TIMEOUT
- err_starve  out  NPORTS  sticky: oldest request bypassed more than MAX_BYPASS times
- viol_count  out  16  saturating count of cycles containing ≥1 new error event
- all_idle  out  1  high when no port has an outstanding request

## Operation
- Per port: FIFO of DEPTH age counters. Push at age 0 on nonzero cmd; pop head on nonzero resp.
- Each enabled cycle, every stored age increments, saturating at TIMEOUT. The increment also applies to entries pushed in an earlier cycle.
- Same-cycle pop and push on one port: pop first, then push. A full FIFO with a simultaneous pop accepts the push with no overflow.
- Response on an empty port sets err_spurious, including when a push occurs in the same cycle. The push still occurs.
- Overflow: the request is dropped and err_overflow is set. The FIFO is unchanged.
- Timeout: set when any entry's age becomes TIMEOUT. The entry remains until popped.
- Bypass counter per port (width clog2(MAX_BYPASS+2), saturating):
  - If port q does not pop this cycle and its head is valid, the counter increments by the number of ports p≠q that pop a head with age strictly less than q's head age.
  - Equal ages are not a bypass.
  - The counter clears when q pops or its FIFO empties.
- err_starve sets when the counter exceeds MAX_BYPASS.
- viol_count increments by 1 in any cycle where any error bit transitions 0→1 or a repeat event of an already-set bit occurs. It saturates at 16'hFFFF.
- enable low: no push/pop/age/bypass/count changes, even if inputs are active.

## Timing
- Reset values: all err_* = 0, viol_count = 0, all_idle = 1, FIFOs empty, bypass counters 0.
- Reset has priority over enable and over any same-cycle event. Reset mid-traffic discards all outstanding entries.
- Error flags and viol_count are registered: visible 1 cycle after the offending input edge.
- Timeout example: a request sampled at edge E0 and never answered has age TIMEOUT at edge E_TIMEOUT. err_timeout is high after E_TIMEOUT.
- all_idle reflects registered FIFO occupancy: it drops after the push edge and rises after the last pop edge.

## Structure
- Package calc_mon_pkg: RESP_NONE/OK/OVF/INV codes, CMD_NOP = 0, clog2 function.
- Sub-module calc_mon_port_fifo contains one port's age FIFO (head/tail pointers, count, age array, head_age, full/empty) plus push/pop/age_en inputs. It is instantiated NPORTS times via generate.
- Top-level contains the bypass comparison network, the error flags and the counter.

## Test plan
- Port 1 cmd=1 at cycle 0, resp=01 at cycle 3 → no errors; all_idle low cycles 1–3, high from cycle 4.
- Port 2 resp=01 with empty FIFO → err_spurious[1]=1 next cycle, viol_count=1.
- Port 3 issues 5 requests on consecutive cycles with no responses (DEPTH=4) → err_overflow[2]=1 after the 5th. Then a 6th request with a same-cycle resp → no new event.
- Port 4 single request, no response for 64 cycles → err_timeout[3] rises exactly after the 64th edge, not the 63rd.
- Port 1 requests at cycle 0. Ports 2–4 request at cycles 1, 2, 3; their responses then arrive one at a time, then one more request/response pair on port 2 follows. With MAX_BYPASS=3, err_starve[0]=1 after the 4th bypass only.
- Traffic active, reset pulsed 1 cycle → all outputs at reset values next cycle. A subsequent response on the previously busy port → err_spurious.
